cache_refill_ctrl: RTL and testbench

Miss-handling engine on the memory side of the 2-way cache bank. It accepts a miss (plus an optional dirty-victim writeback) from the bank and writes the victim line back to memory. It then fetches the new line in 2-word beats and streams each beat into the bank over the refill port (`addr_rd`/`data_rd`/`wen_rd`/`set_rd`), closing with `finish_rd`. It also drives the bank's `busy_wb`/`busy_rd` back-pressure.

---
 rtl/cache_refill_ctrl.sv | 151 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine for the 2-way cache bank: victim writeback,
// beat-wise line refill into the bank, and bank back-pressure.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_cache,
    input  logic [ADDR_WIDTH-1:0]          addr_cache,
    input  logic                           set_cache,
    input  logic                           need_wb,
    input  logic [ADDR_WIDTH-1:0]          addr_wb,
    input  logic [BANK_NUM*DATA_WIDTH-1:0] data_wb,
    output logic                           busy_wb,
    output logic                           busy_rd,
    output logic [ADDR_WIDTH-1:0]          addr_rd,
    output logic [2*DATA_WIDTH-1:0]        data_rd,
    output logic                           wen_rd,
    output logic                           set_rd,
    output logic                           finish_rd,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_wen,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic [2*DATA_WIDTH-1:0]        mem_req_wdata,
    input  logic                           mem_resp_valid,
    input  logic [2*DATA_WIDTH-1:0]        mem_resp_rdata
);

    localparam int BEATS    = BANK_NUM / 2;
    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTE_NUM = DATA_WIDTH / 8;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WB      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    logic [2:0]                    state;
    logic [BW-1:0]                 beat;
    logic [ADDR_WIDTH-1:0]         rd_base;
    logic [ADDR_WIDTH-1:0]         wb_base;
    logic [BANK_NUM*DATA_WIDTH-1:0] wb_line;
    logic                          way;

    logic [ADDR_WIDTH-1:0] beat_off;
    logic [ADDR_WIDTH-1:0] wb_beat_addr;
    logic [ADDR_WIDTH-1:0] rd_beat_addr;
    logic                  last;

    // Line bases are aligned, so the offset never carries out of the line.
    assign beat_off     = ADDR_WIDTH'(beat) * ADDR_WIDTH'(2 * BYTE_NUM);
    assign wb_beat_addr = wb_base + beat_off;
    assign rd_beat_addr = rd_base + beat_off;
    assign last         = (beat == LAST_BEAT);

    assign busy_rd = (state != S_IDLE);
    assign busy_wb = (state == S_WB);
    assign set_rd  = way;

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = rd_beat_addr;
        mem_req_wdata = wb_line[int'(beat)*2*DATA_WIDTH +: 2*DATA_WIDTH];
        if (state == S_WB) begin
            mem_req_valid = 1'b1;
            mem_req_wen   = 1'b1;
            mem_req_addr  = wb_beat_addr;
        end else if (state == S_RD_REQ) begin
            mem_req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beat      <= '0;
            rd_base   <= '0;
            wb_base   <= '0;
            wb_line   <= '0;
            way       <= 1'b0;
            addr_rd   <= '0;
            data_rd   <= '0;
            wen_rd    <= 1'b0;
            finish_rd <= 1'b0;
        end else begin
            wen_rd    <= 1'b0;
            finish_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (miss_cache) begin
                        rd_base <= addr_cache;
                        way     <= set_cache;
                        beat    <= '0;
                        if (need_wb) begin
                            wb_base <= addr_wb;
                            wb_line <= data_wb;
                            state   <= S_WB;
                        end else begin
                            state   <= S_RD_REQ;
                        end
                    end
                end
                S_WB: begin
                    if (mem_req_ready) begin
                        if (last) begin
                            beat  <= '0;
                            state <= S_RD_REQ;
                        end else begin
                            beat  <= beat + 1'b1;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (mem_req_ready) state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_resp_valid) begin
                        data_rd <= mem_resp_rdata;
                        addr_rd <= rd_beat_addr;
                        wen_rd  <= 1'b1;
                        if (last) begin
                            state <= S_FIN;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= S_RD_REQ;
                        end
                    end
                end
                S_FIN: begin
                    // First FIN cycle arms the pulse; second emits it and leaves.
                    if (!finish_rd) begin
                        finish_rd <= 1'b1;
                        addr_rd   <= rd_base;
                    end else begin
                        beat  <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a small zero-wait/stalling
// memory responder and an event log of handshakes, beats and finishes.
module tb_cache_refill_ctrl;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              miss_cache = 1'b0;
    logic [AW-1:0]     addr_cache = '0;
    logic              set_cache = 1'b0;
    logic              need_wb = 1'b0;
    logic [AW-1:0]     addr_wb = '0;
    logic [BN*DW-1:0]  data_wb = '0;
    logic              busy_wb, busy_rd, wen_rd, set_rd, finish_rd;
    logic [AW-1:0]     addr_rd;
    logic [2*DW-1:0]   data_rd;
    logic              mem_req_valid, mem_req_ready, mem_req_wen;
    logic [AW-1:0]     mem_req_addr;
    logic [2*DW-1:0]   mem_req_wdata;
    logic              mem_resp_valid;
    logic [2*DW-1:0]   mem_resp_rdata;

    cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) dut (
        .clk(clk), .rst(rst),
        .miss_cache(miss_cache), .addr_cache(addr_cache), .set_cache(set_cache),
        .need_wb(need_wb), .addr_wb(addr_wb), .data_wb(data_wb),
        .busy_wb(busy_wb), .busy_rd(busy_rd),
        .addr_rd(addr_rd), .data_rd(data_rd), .wen_rd(wen_rd),
        .set_rd(set_rd), .finish_rd(finish_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    // Memory: responds the cycle after a read is accepted; optional 5-cycle stall.
    logic            resp_v = 1'b0;
    logic [2*DW-1:0] resp_d = '0;
    logic            stray = 1'b0;
    logic            stall_mode = 1'b0;
    logic            rdy_force = 1'b1;
    int              scnt = 0;
    int              cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            resp_v <= 1'b0;
            resp_d <= '0;
        end else begin
            resp_v <= mem_req_valid && mem_req_ready && !mem_req_wen;
            resp_d <= {64'hD0D0_0000_0000_0000 | (mem_req_addr + 64'h8),
                       64'hD0D0_0000_0000_0000 | mem_req_addr};
        end
        if (mem_req_valid && !mem_req_ready) scnt <= scnt + 1;
        else scnt <= 0;
    end

    assign mem_resp_valid = resp_v | stray;
    assign mem_resp_rdata = resp_d;
    assign mem_req_ready  = stall_mode ? (scnt == 5) : rdy_force;

    // Event log, sampled just after the falling edge.
    logic [AW-1:0]   w_addr [32];
    logic [2*DW-1:0] w_data [32];
    int              w_cyc  [32];
    logic [AW-1:0]   r_addr [32];
    int              r_cyc  [32];
    int              rs_cyc [32];
    logic [AW-1:0]   wen_addr [32];
    logic [2*DW-1:0] wen_data [32];
    logic            wen_set  [32];
    int              wen_cyc  [32];
    logic [AW-1:0]   fin_addr [32];
    int              fin_cyc  [32];
    int nw = 0, nr = 0, nrs = 0, nwen = 0, nfin = 0;
    int bwb_cnt = 0, busy_fall = 0, unstable = 0;
    logic            p_valid = 1'b0, p_ready = 1'b0, p_busy = 1'b0;
    logic [AW-1:0]   p_addr = '0;
    logic [2*DW-1:0] p_wdata = '0;

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (mem_req_valid && mem_req_ready && mem_req_wen && nw < 32) begin
                w_addr[nw] <= mem_req_addr;
                w_data[nw] <= mem_req_wdata;
                w_cyc[nw]  <= cyc;
                nw <= nw + 1;
            end
            if (mem_req_valid && mem_req_ready && !mem_req_wen && nr < 32) begin
                r_addr[nr] <= mem_req_addr;
                r_cyc[nr]  <= cyc;
                nr <= nr + 1;
            end
            if (resp_v && nrs < 32) begin
                rs_cyc[nrs] <= cyc;
                nrs <= nrs + 1;
            end
            if (wen_rd && nwen < 32) begin
                wen_addr[nwen] <= addr_rd;
                wen_data[nwen] <= data_rd;
                wen_set[nwen]  <= set_rd;
                wen_cyc[nwen]  <= cyc;
                nwen <= nwen + 1;
            end
            if (finish_rd && nfin < 32) begin
                fin_addr[nfin] <= addr_rd;
                fin_cyc[nfin]  <= cyc;
                nfin <= nfin + 1;
            end
            if (busy_wb) bwb_cnt <= bwb_cnt + 1;
            if (p_busy && !busy_rd) busy_fall <= cyc;
            if (p_valid && !p_ready && mem_req_valid &&
                (mem_req_addr !== p_addr ||
                 (mem_req_wen && mem_req_wdata !== p_wdata)))
                unstable <= unstable + 1;
        end
        p_valid <= mem_req_valid;
        p_ready <= mem_req_ready;
        p_addr  <= mem_req_addr;
        p_wdata <= mem_req_wdata;
        p_busy  <= busy_rd;
    end

    int n_assert = 0;
    int n_fail = 0;
    int c0, b_w, b_r, b_rs, b_wen, b_f, b_bwb;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_w = nw; b_r = nr; b_rs = nrs; b_wen = nwen; b_f = nfin; b_bwb = bwb_cnt;
    endtask

    task automatic do_miss(input logic [AW-1:0] a, input logic s, input logic wb,
                           input logic [AW-1:0] awb, input logic [BN*DW-1:0] dwb);
        @(negedge clk);
        miss_cache = 1'b1; addr_cache = a; set_cache = s;
        need_wb = wb; addr_wb = awb; data_wb = dwb;
        c0 = cyc;
        @(negedge clk);
        miss_cache = 1'b0; need_wb = 1'b0;
        addr_cache = '1; set_cache = ~s;
        addr_wb = '1; data_wb = {BN{64'hDEAD_BEEF_DEAD_BEEF}};
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (busy_rd !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 128'(k < 200), 128'd1);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_flags", {busy_rd, busy_wb, wen_rd, finish_rd, set_rd,
                            mem_req_valid, mem_req_wen}, 0);
        chk("reset_addr_rd", addr_rd, 0);
        chk("reset_data_rd", data_rd, 0);
        rst = 1'b0;

        // Clean miss
        snap();
        do_miss(64'h1040, 1'b1, 1'b0, '0, '0);
        chk("clean_req_c1", mem_req_valid, 1);
        wait_done("clean_done");
        chk("clean_nrd", nr - b_r, 2);
        chk("clean_rd0", r_addr[b_r], 64'h1040);
        chk("clean_rd1", r_addr[b_r+1], 64'h1050);
        chk("clean_rd0_cyc", r_cyc[b_r] - c0, 1);
        chk("clean_nwr", nw - b_w, 0);
        chk("clean_nwen", nwen - b_wen, 2);
        chk("clean_wen0_addr", wen_addr[b_wen], 64'h1040);
        chk("clean_wen1_addr", wen_addr[b_wen+1], 64'h1050);
        chk("clean_wen0_data", wen_data[b_wen], 128'hD0D0000000001048_D0D0000000001040);
        chk("clean_wen1_data", wen_data[b_wen+1], 128'hD0D0000000001058_D0D0000000001050);
        chk("clean_wen_set", {wen_set[b_wen], wen_set[b_wen+1]}, 2'b11);
        chk("clean_wen0_lat", wen_cyc[b_wen] - rs_cyc[b_rs], 1);
        chk("clean_wen1_lat", wen_cyc[b_wen+1] - rs_cyc[b_rs+1], 1);
        chk("clean_req1_cyc", r_cyc[b_r+1], wen_cyc[b_wen]);
        chk("clean_nfin", nfin - b_f, 1);
        chk("clean_fin_addr", fin_addr[b_f], 64'h1040);
        chk("clean_fin_cyc", fin_cyc[b_f] - wen_cyc[b_wen+1], 1);
        chk("clean_busy_fall", busy_fall - fin_cyc[b_f], 1);
        chk("clean_no_busy_wb", bwb_cnt - b_bwb, 0);

        // Dirty miss
        snap();
        do_miss(64'h3080, 1'b0, 1'b1, 64'h2000,
                {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        chk("dirty_busy_wb_c1", busy_wb, 1);
        chk("dirty_wen_c1", {mem_req_valid, mem_req_wen}, 2'b11);
        wait_done("dirty_done");
        chk("dirty_nwr", nw - b_w, 2);
        chk("dirty_wr0_addr", w_addr[b_w], 64'h2000);
        chk("dirty_wr1_addr", w_addr[b_w+1], 64'h2010);
        chk("dirty_wr0_data", w_data[b_w], 128'h00000000000000A1_00000000000000A0);
        chk("dirty_wr1_data", w_data[b_w+1], 128'h00000000000000A3_00000000000000A2);
        chk("dirty_wr0_cyc", w_cyc[b_w] - c0, 1);
        chk("dirty_rd0_addr", r_addr[b_r], 64'h3080);
        chk("dirty_rd1_addr", r_addr[b_r+1], 64'h3090);
        chk("dirty_rd_after_wb", r_cyc[b_r] - w_cyc[b_w+1], 1);
        chk("dirty_wen_set", {wen_set[b_wen], wen_set[b_wen+1]}, 2'b00);
        chk("dirty_fin_addr", fin_addr[b_f], 64'h3080);
        chk("dirty_busy_wb_cnt", bwb_cnt - b_bwb, 2);

        // Request stall of 5 cycles on every beat
        snap();
        stall_mode = 1'b1;
        do_miss(64'h4000, 1'b1, 1'b1, 64'h5000,
                {64'hB3, 64'hB2, 64'hB1, 64'hB0});
        wait_done("stall_done");
        stall_mode = 1'b0;
        chk("stall_wr0_cyc", w_cyc[b_w] - c0, 6);
        chk("stall_wr0_data", w_data[b_w], 128'h00000000000000B1_00000000000000B0);
        chk("stall_wr1_data", w_data[b_w+1], 128'h00000000000000B3_00000000000000B2);
        chk("stall_wr1_addr", w_addr[b_w+1], 64'h5010);
        chk("stall_stable", unstable, 0);
        chk("stall_nwen", nwen - b_wen, 2);
        chk("stall_wen0_lat", wen_cyc[b_wen] - rs_cyc[b_rs], 1);
        chk("stall_wen1_lat", wen_cyc[b_wen+1] - rs_cyc[b_rs+1], 1);
        chk("stall_wen0_data", wen_data[b_wen], 128'hD0D0000000004008_D0D0000000004000);
        chk("stall_wen1_data", wen_data[b_wen+1], 128'hD0D0000000004018_D0D0000000004010);
        chk("stall_fin_addr", fin_addr[b_f], 64'h4000);

        // Stray traffic
        snap();
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_idle", {wen_rd, busy_rd, mem_req_valid}, 3'b000);
        rdy_force = 1'b0;
        do_miss(64'h8000, 1'b0, 1'b0, '0, '0);
        chk("stray_req_c1", mem_req_valid, 1);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_rdreq", {wen_rd, mem_req_valid, mem_req_wen}, 3'b010);
        chk("stray_rdreq_addr", mem_req_addr, 64'h8000);
        miss_cache = 1'b1; addr_cache = 64'h9000; set_cache = 1'b1;
        need_wb = 1'b1; addr_wb = 64'hA000;
        @(negedge clk);
        miss_cache = 1'b0; need_wb = 1'b0;
        chk("stray_miss_busy", {busy_wb, set_rd, mem_req_wen}, 3'b000);
        chk("stray_miss_addr", mem_req_addr, 64'h8000);
        rdy_force = 1'b1;
        wait_done("stray_done");
        repeat (3) @(negedge clk);
        #2;
        chk("stray_nrd", nr - b_r, 2);
        chk("stray_rd0", r_addr[b_r], 64'h8000);
        chk("stray_rd1", r_addr[b_r+1], 64'h8010);
        chk("stray_nwr", nw - b_w, 0);
        chk("stray_nwen", nwen - b_wen, 2);
        chk("stray_nfin", nfin - b_f, 1);
        chk("stray_idle_end", busy_rd, 0);

        // Reset in RD_WAIT of beat 1
        snap();
        do_miss(64'h6000, 1'b1, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_in_rdwait", {busy_rd, mem_req_valid}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_flags", {busy_rd, busy_wb, wen_rd, finish_rd, set_rd,
                              mem_req_valid, mem_req_wen}, 0);
        chk("rst_mid_addr_rd", addr_rd, 0);
        chk("rst_mid_data_rd", data_rd, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("rst_no_finish", nfin - b_f, 0);
        snap();
        do_miss(64'h7000, 1'b1, 1'b0, '0, '0);
        wait_done("post_rst_done");
        chk("post_rst_nwen", nwen - b_wen, 2);
        chk("post_rst_wen0", wen_addr[b_wen], 64'h7000);
        chk("post_rst_wen1_data", wen_data[b_wen+1], 128'hD0D0000000007018_D0D0000000007010);
        chk("post_rst_fin", {28'(nfin - b_f), fin_addr[b_f]}, {28'd1, 64'h7000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
